// File: rtl/camera_capture_ctrl_if.sv
// Sensor-style video bus (data, frame valid, line valid) shared by the
// raw sensor pins and the gated output toward the Bayer stage.
interface camera_capture_ctrl_if;
    logic [11:0] D;
    logic        FVAL;
    logic        LVAL;

    modport master (output D, FVAL, LVAL);
    modport slave  (input  D, FVAL, LVAL);
endinterface

// File: rtl/camera_capture_ctrl.sv
// Frame-level capture sequencer: gates whole sensor frames into the pixel
// pipeline, with decimation, single-shot, overflow abort and geometry checks.
module camera_capture_ctrl #(
    parameter int VIDEO_W = 1920,
    parameter int VIDEO_H = 1080,
    parameter int SKIP_W  = 4
) (
    input  logic                   CAMERA_PIXCLK,
    input  logic                   reset_n,
    camera_capture_ctrl_if.slave   cam_if,
    camera_capture_ctrl_if.master  out_if,
    input  logic                   cfg_run,
    input  logic                   cfg_single,
    input  logic [SKIP_W-1:0]      cfg_skip,
    input  logic                   fifo_full,
    input  logic                   err_clr,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            ovf_cnt,
    output logic                   size_err,
    output logic                   ovf_err
);
    typedef enum logic [2:0] {IDLE, WAIT_GAP, ARMED, CAPTURE, SKIP} state_e;

    state_e              state_q, state_d;
    logic                run_meta_q, run_s_q;
    logic                fval_prev_q, lval_prev_q;
    logic                single_done_q, single_done_d;
    logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic                abort_q, abort_d;
    logic [15:0]         pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d, ovf_cnt_q, ovf_cnt_d;
    logic                size_err_q, size_err_d, ovf_err_q, ovf_err_d;
    logic                frame_done_q, frame_done_d, busy_q;
    logic [11:0]         out_d_q;
    logic                out_fval_q, out_lval_q;

    logic                fstart, fend, lval_fall, cap_next, in_frame;
    logic                ovf_hit, size_hit;
    logic [15:0]         pix_base, line_base;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign fstart    = cam_if.FVAL & ~fval_prev_q;
    assign fend      = ~cam_if.FVAL & fval_prev_q;
    assign lval_fall = ~cam_if.LVAL & lval_prev_q;

    always_comb begin
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        // A finished single shot holds off re-arming until run is dropped.
        single_done_d = single_done_q & run_s_q;
        frame_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                skip_cnt_d = '0;
                if (run_s_q && !single_done_q) state_d = WAIT_GAP;
            end
            WAIT_GAP: if (!cam_if.FVAL) state_d = ARMED;
            ARMED: begin
                if (!run_s_q) begin
                    state_d = IDLE;
                end else if (fstart) begin
                    if (skip_cnt_q == '0) begin
                        state_d    = CAPTURE;
                        skip_cnt_d = cfg_skip;
                    end else begin
                        state_d    = SKIP;
                        skip_cnt_d = skip_cnt_q - 1'b1;
                    end
                end
            end
            SKIP: if (fend) state_d = run_s_q ? ARMED : IDLE;
            CAPTURE: begin
                if (fend) begin
                    frame_done_d  = 1'b1;
                    single_done_d = cfg_single & run_s_q;
                    state_d       = (cfg_single || !run_s_q) ? IDLE : ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cap_next = (state_d == CAPTURE);
    // Include the frame-end cycle so a line closing with FVAL still counts.
    assign in_frame = cap_next | (state_q == CAPTURE);

    always_comb begin
        pix_base   = (state_q != CAPTURE) ? 16'd0 : pix_cnt_q;
        line_base  = (state_q != CAPTURE) ? 16'd0 : line_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        size_hit   = 1'b0;
        abort_d    = fstart ? 1'b0 : abort_q;
        if (state_q == CAPTURE && fifo_full) abort_d = 1'b1;
        ovf_hit    = (state_q == CAPTURE) & fifo_full & ~abort_q;
        if (in_frame) begin
            pix_cnt_d  = pix_base;
            line_cnt_d = line_base;
            if (cam_if.LVAL && cam_if.FVAL) begin
                pix_cnt_d = sat_inc(pix_base);
            end else if (lval_fall && state_q == CAPTURE) begin
                if (pix_base != 16'(VIDEO_W) && !abort_d) size_hit = 1'b1;
                pix_cnt_d  = '0;
                line_cnt_d = sat_inc(line_base);
            end
        end
        if (state_q == CAPTURE && fend && !abort_d && line_cnt_d != 16'(VIDEO_H))
            size_hit = 1'b1;
        frame_cnt_d = frame_done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
        ovf_cnt_d   = ovf_hit ? ovf_cnt_q + 16'd1 : ovf_cnt_q;
        size_err_d  = size_hit | (size_err_q & ~err_clr);
        ovf_err_d   = ovf_hit | (ovf_err_q & ~err_clr);
    end

    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            run_meta_q    <= 1'b0;
            run_s_q       <= 1'b0;
            fval_prev_q   <= 1'b0;
            lval_prev_q   <= 1'b0;
            single_done_q <= 1'b0;
            skip_cnt_q    <= '0;
            abort_q       <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            ovf_cnt_q     <= '0;
            size_err_q    <= 1'b0;
            ovf_err_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            out_d_q       <= '0;
            out_fval_q    <= 1'b0;
            out_lval_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_meta_q    <= cfg_run;
            run_s_q       <= run_meta_q;
            fval_prev_q   <= cam_if.FVAL;
            lval_prev_q   <= cam_if.LVAL;
            single_done_q <= single_done_d;
            skip_cnt_q    <= skip_cnt_d;
            abort_q       <= abort_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            ovf_cnt_q     <= ovf_cnt_d;
            size_err_q    <= size_err_d;
            ovf_err_q     <= ovf_err_d;
            frame_done_q  <= frame_done_d;
            // Registered so busy falls the cycle after frame_done.
            busy_q        <= (state_q != IDLE);
            out_d_q       <= cap_next ? cam_if.D : 12'd0;
            out_fval_q    <= cam_if.FVAL & cap_next;
            out_lval_q    <= cam_if.LVAL & cam_if.FVAL & cap_next & ~abort_d;
        end
    end

    assign out_if.D    = out_d_q;
    assign out_if.FVAL = out_fval_q;
    assign out_if.LVAL = out_lval_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign ovf_cnt     = ovf_cnt_q;
    assign size_err    = size_err_q;
    assign ovf_err     = ovf_err_q;
endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Bench for camera_capture_ctrl: small frame geometry, scenario table plus
// hand sequences for mid-frame run and mid-frame reset.
module tb_camera_capture_ctrl;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    camera_capture_ctrl_if cam ();
    camera_capture_ctrl_if vout ();

    logic          cfg_run = 1'b0, cfg_single = 1'b0;
    logic [SW-1:0] cfg_skip = '0;
    logic          fifo_full = 1'b0, err_clr = 1'b0;
    logic          busy, frame_done, size_err, ovf_err;
    logic [15:0]   frame_cnt, ovf_cnt;

    camera_capture_ctrl #(.VIDEO_W(W), .VIDEO_H(H), .SKIP_W(SW)) dut (
        .CAMERA_PIXCLK(clk), .reset_n(reset_n),
        .cam_if(cam.slave), .out_if(vout.master),
        .cfg_run(cfg_run), .cfg_single(cfg_single), .cfg_skip(cfg_skip),
        .fifo_full(fifo_full), .err_clr(err_clr),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .ovf_cnt(ovf_cnt), .size_err(size_err), .ovf_err(ovf_err)
    );

    typedef struct { logic [11:0] d; logic fval; logic lval; logic done; } exp_t;
    typedef struct {
        bit single; logic [SW-1:0] skip; int nfr; logic [15:0] mask;
        int short_fr; int ovf_fr; int fcnt; int ovfc; bit serr; bit oerr;
    } scen_t;

    exp_t  q[$];
    scen_t tbl[5];
    int    checks = 0, errors = 0;
    bit    prev_fv = 0, ab = 0, full_req = 0, busy_chk = 0;
    logic [15:0] fb, ob;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One pixel clock: score the previous cycle's output, then drive and predict.
    task automatic tick(input logic [11:0] d, input bit fv, input bit lv, input bit cap);
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_D", vout.D, e.d);
            chk("out_FVAL", vout.FVAL, e.fval);
            chk("out_LVAL", vout.LVAL, e.lval);
            chk("frame_done", frame_done, e.done);
            if (busy_chk) begin
                chk("busy_drop", busy, 0);
                busy_chk = 0;
            end
            if (e.done && cfg_single) begin
                chk("busy_at_done", busy, 1);
                busy_chk = 1;
            end
        end
        cam.D = d; cam.FVAL = fv; cam.LVAL = lv; fifo_full = full_req;
        if (full_req) ab = 1;
        e.d    = (fv && cap) ? d : 12'd0;
        e.fval = fv & cap;
        e.lval = fv & lv & cap & ~ab;
        e.done = cap & prev_fv & ~fv;
        q.push_back(e);
        prev_fv = fv;
    endtask

    task automatic mid_reset();
        #2;
        chk("pre_rst_FVAL", vout.FVAL, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_out_FVAL", vout.FVAL, 0);
        chk("rst_out_LVAL", vout.LVAL, 0);
        chk("rst_out_D", vout.D, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
        q.delete();
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic frame(input int nl, input bit cap_in, input int ovf_line,
                         input int run_line, input int rst_line);
        bit cap;
        cap = cap_in;
        ab = 0;
        repeat (2) tick(0, 1, 0, cap);
        for (int l = 0; l < nl; l++) begin
            if (l == run_line) cfg_run = 1'b1;
            for (int p = 0; p < W; p++) begin
                if (l == rst_line && p == 4) begin
                    mid_reset();
                    cap = 0;
                end
                full_req = (l == ovf_line && p == 1);
                tick(12'($urandom_range(1, 4095)), 1, 1, cap);
            end
            full_req = 0;
            repeat (2) tick(0, 1, 0, cap);
        end
        repeat (4) tick(0, 0, 0, cap);
    endtask

    initial begin
        tbl[0] = '{0, 4'd0, 3, 16'b111,       -1, -1, 3, 0, 0, 0};
        tbl[1] = '{0, 4'd2, 9, 16'b001001001, -1, -1, 3, 0, 0, 0};
        tbl[2] = '{1, 4'd0, 3, 16'b001,       -1, -1, 1, 0, 0, 0};
        tbl[3] = '{0, 4'd0, 2, 16'b11,        -1,  0, 2, 1, 0, 1};
        tbl[4] = '{0, 4'd0, 2, 16'b11,         0, -1, 2, 0, 1, 0};

        cam.D = '0; cam.FVAL = 1'b0; cam.LVAL = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_D", vout.D, 0);
        chk("reset_out_FVAL", vout.FVAL, 0);
        chk("reset_out_LVAL", vout.LVAL, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_ovf_cnt", ovf_cnt, 0);
        chk("reset_size_err", size_err, 0);
        chk("reset_ovf_err", ovf_err, 0);
        reset_n = 1'b1;

        for (int s = 0; s < 5; s++) begin
            fb = frame_cnt;
            ob = ovf_cnt;
            cfg_single = tbl[s].single;
            cfg_skip   = tbl[s].skip;
            cfg_run    = 1'b1;
            repeat (6) tick(0, 0, 0, 0);
            for (int f = 0; f < tbl[s].nfr; f++)
                frame((f == tbl[s].short_fr) ? H - 1 : H, tbl[s].mask[f],
                      (f == tbl[s].ovf_fr) ? 2 : -1, -1, -1);
            chk($sformatf("s%0d_frame_cnt", s), 16'(frame_cnt - fb), tbl[s].fcnt);
            chk($sformatf("s%0d_ovf_cnt", s), 16'(ovf_cnt - ob), tbl[s].ovfc);
            chk($sformatf("s%0d_size_err", s), size_err, tbl[s].serr);
            chk($sformatf("s%0d_ovf_err", s), ovf_err, tbl[s].oerr);
            cfg_run = 1'b0;
            repeat (5) tick(0, 0, 0, 0);
            chk($sformatf("s%0d_idle_busy", s), busy, 0);
            err_clr = 1'b1;
            tick(0, 0, 0, 0);
            err_clr = 1'b0;
            tick(0, 0, 0, 0);
            chk($sformatf("s%0d_clr_size_err", s), size_err, 0);
            chk($sformatf("s%0d_clr_ovf_err", s), ovf_err, 0);
        end

        // Run asserted mid-frame: that frame is skipped, the next one is whole.
        cfg_single = 1'b0;
        cfg_skip   = '0;
        fb = frame_cnt;
        frame(H, 0, -1, 1, -1);
        frame(H, 1, -1, -1, -1);
        chk("midrun_frame_cnt", 16'(frame_cnt - fb), 1);
        chk("midrun_size_err", size_err, 0);

        // Reset mid-frame: outputs clear at once, rest of the frame blocked.
        frame(H, 1, -1, -1, 1);
        frame(H, 1, -1, -1, -1);
        chk("postrst_frame_cnt", frame_cnt, 1);
        chk("postrst_size_err", size_err, 0);
        cfg_run = 1'b0;
        repeat (4) tick(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
